// File: rtl/acc_ram_rmw_if.sv
// Operation/result bundle for the accumulator RAM.
// The master drives operations; the slave is the RAM.
interface acc_ram_rmw_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13
);
  logic              en_i;
  logic [1:0]        op_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              clr_ovf_i;
  logic [DATA_W-1:0] rdata_o;
  logic              rvalid_o;
  logic              ovf_o;

  modport master (
    output en_i, op_i, addr_i, wdata_i, clr_ovf_i,
    input  rdata_o, rvalid_o, ovf_o
  );

  modport slave (
    input  en_i, op_i, addr_i, wdata_i, clr_ovf_i,
    output rdata_o, rvalid_o, ovf_o
  );
endinterface

// File: rtl/acc_ram_rmw.sv
// Accumulator RAM with READ / WRITE / ACC / RCLR.
// Two-stage read-modify-write runs at one op per cycle, with stage-1 to stage-0 forwarding.
module acc_ram_rmw #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 13,
  parameter bit SATURATE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  acc_ram_rmw_if.slave bus
);
  localparam int LSB    = $clog2(DATA_W / 8);
  localparam int WORD_W = ADDR_W - LSB;
  localparam int DEPTH  = 32'd1 << WORD_W;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ACC   = 2'b10;
  localparam logic [1:0] OP_RCLR  = 2'b11;

  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  // Signed add; returns {overflow, result}. The result is clamped or wrapped as configured.
  function automatic logic [DATA_W:0] acc_add(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      if (SATURATE) begin
        acc_add = {1'b1, (sum[DATA_W] ? MIN_V : MAX_V)};
      end else begin
        acc_add = {1'b1, sum[DATA_W-1:0]};
      end
    end else begin
      acc_add = {1'b0, sum[DATA_W-1:0]};
    end
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              s1_vld_q;
  logic [1:0]        s1_op_q;
  logic [WORD_W-1:0] s1_word_q;
  logic [DATA_W-1:0] s1_wdata_q;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              ovf_q, ovf_d;

  logic [WORD_W-1:0] word_s;
  logic [DATA_W-1:0] result_s;
  logic              ovf_hit_s;
  logic              s1_wr_s;
  logic              unused_s;

  assign word_s   = bus.addr_i[ADDR_W-1:LSB];
  assign unused_s = ^bus.addr_i[LSB-1:0];

  // Stage-1 result, overflow detection, forwarding mux and output next-state.
  always_comb begin
    result_s  = {DATA_W{1'b0}};
    ovf_hit_s = 1'b0;
    case (s1_op_q)
      OP_WRITE: result_s = s1_wdata_q;
      OP_ACC:   {ovf_hit_s, result_s} = acc_add(rd_q, s1_wdata_q);
      OP_RCLR:  result_s = {DATA_W{1'b0}};
      default:  result_s = {DATA_W{1'b0}};
    endcase
    ovf_hit_s = ovf_hit_s & s1_vld_q;
    s1_wr_s   = s1_vld_q && (s1_op_q != OP_READ);

    // A write still in flight to the word being read must win over the array.
    if (s1_wr_s && (s1_word_q == word_s)) begin
      rd_d = result_s;
    end else begin
      rd_d = mem_q[word_s];
    end

    rvalid_d = bus.en_i && ((bus.op_i == OP_READ) || (bus.op_i == OP_RCLR));
    if (rvalid_d) begin
      rdata_d = rd_d;
    end else begin
      rdata_d = rdata_q;
    end

    if (ovf_hit_s) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Pipeline registers and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_op_q    <= OP_READ;
      s1_word_q  <= {WORD_W{1'b0}};
      s1_wdata_q <= {DATA_W{1'b0}};
      rd_q       <= {DATA_W{1'b0}};
      rdata_q    <= {DATA_W{1'b0}};
      rvalid_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s1_vld_q   <= bus.en_i;
      s1_op_q    <= bus.op_i;
      s1_word_q  <= word_s;
      s1_wdata_q <= bus.wdata_i;
      rd_q       <= rd_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      ovf_q      <= ovf_d;
    end
  end

  // Array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (s1_wr_s) begin
      mem_q[s1_word_q] <= result_s;
    end
  end

  assign bus.rdata_o  = rdata_q;
  assign bus.rvalid_o = rvalid_q;
  assign bus.ovf_o    = ovf_q;
endmodule
